// File: rtl/cnn_relu_maxpool_3x3_s2_if.sv
// rtl/cnn_relu_maxpool_3x3_s2_if.sv - pixel stream in / pooled stream out bundle for the relu+maxpool stage
interface cnn_relu_maxpool_3x3_s2_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] pxl_in;
  logic [DATA_WIDTH-1:0] pxl_out;
  logic                  valid_out;
  logic                  last_out;

  modport master (
    output valid_in,
    output pxl_in,
    input  pxl_out,
    input  valid_out,
    input  last_out
  );

  modport slave (
    input  valid_in,
    input  pxl_in,
    output pxl_out,
    output valid_out,
    output last_out
  );
endinterface

// File: rtl/cnn_relu_maxpool_3x3_s2.sv
// rtl/cnn_relu_maxpool_3x3_s2.sv - fused ReLU + 3x3/stride-2/pad-1 max-pool over per-channel raster planes
module cnn_relu_maxpool_3x3_s2 #(
  parameter int DATA_WIDTH   = 32,
  parameter int IMAGE_WIDTH  = 112,
  parameter int IMAGE_HEIGHT = 112,
  parameter int CHANNEL_NUM  = 64
) (
  input logic                     clk,
  input logic                     reset,
  cnn_relu_maxpool_3x3_s2_if.slave io
);
  localparam int CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int NW = (CHANNEL_NUM  > 1) ? $clog2(CHANNEL_NUM)  : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [NW-1:0] chan;

  logic [DATA_WIDTH-1:0] lb_a [IMAGE_WIDTH];
  logic [DATA_WIDTH-1:0] lb_b [IMAGE_WIDTH];

  logic [DATA_WIDTH-1:0] r, lb_b_rd, v, v1, v2, v2_eff, hmax;
  logic                  col_last, row_last, chan_last, fire, frame_last;

  logic                  s1_valid, s1_last;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  out_valid, out_last;
  logic [DATA_WIDTH-1:0] out_data;

  assign col_last   = (col  == CW'(IMAGE_WIDTH - 1));
  assign row_last   = (row  == RW'(IMAGE_HEIGHT - 1));
  assign chan_last  = (chan == NW'(CHANNEL_NUM - 1));
  assign fire       = io.valid_in & row[0] & col[0];
  assign frame_last = col_last & row_last & chan_last;

  // Post-ReLU values are non-negative floats, so unsigned raw-bit compare orders them.
  always_comb begin
    r       = io.pxl_in[DATA_WIDTH-1] ? '0 : io.pxl_in;
    lb_b_rd = (row == RW'(1)) ? '0 : lb_b[col];
    v       = r;
    if (lb_a[col] > v) v = lb_a[col];
    if (lb_b_rd > v)   v = lb_b_rd;
    v2_eff  = (col == CW'(1)) ? '0 : v2;
    hmax    = v;
    if (v1 > hmax)     hmax = v1;
    if (v2_eff > hmax) hmax = v2_eff;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col  <= '0;
      row  <= '0;
      chan <= '0;
    end else if (io.valid_in) begin
      if (col_last) begin
        col <= '0;
        if (row_last) begin
          row  <= '0;
          chan <= chan_last ? '0 : chan + NW'(1);
        end else begin
          row <= row + RW'(1);
        end
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Line buffers and horizontal window hold no control state, so they skip reset.
  always_ff @(posedge clk) begin
    if (io.valid_in) begin
      lb_b[col] <= lb_a[col];
      lb_a[col] <= r;
      if (row[0]) begin
        v2 <= v1;
        v1 <= v;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_data   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      s1_valid  <= fire;
      s1_last   <= fire & frame_last;
      if (fire) s1_data <= hmax;
      out_valid <= s1_valid;
      out_last  <= s1_last;
      if (s1_valid) out_data <= s1_data;
    end
  end

  assign io.pxl_out   = out_data;
  assign io.valid_out = out_valid;
  assign io.last_out  = out_last;
endmodule

// File: tb/tb_cnn_relu_maxpool_3x3_s2.sv
// tb/tb_cnn_relu_maxpool_3x3_s2.sv - scoreboard bench for the relu+maxpool stage on 4x4x2 planes
module tb_cnn_relu_maxpool_3x3_s2;
  typedef logic [15:0][31:0] plane_t;
  typedef logic [3:0][31:0]  pooled_t;

  typedef struct {
    plane_t  pix;
    pooled_t exp;
    bit      gaps;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    longint      due;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset = 1'b0;
  longint cyc = 0;
  int     tests = 0;
  int     fails = 0;
  int     out_idx = 0;
  bit     chan = 1'b0;
  exp_t   sbq [$];

  cnn_relu_maxpool_3x3_s2_if #(.DATA_WIDTH(32)) io ();

  cnn_relu_maxpool_3x3_s2 #(
    .DATA_WIDTH  (32),
    .IMAGE_WIDTH (4),
    .IMAGE_HEIGHT(4),
    .CHANNEL_NUM (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .io   (io)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic logic [31:0] fbits(input int i);
    int          e;
    logic [31:0] m;
    if (i == 0) return 32'h0;
    e = 0;
    while ((i >> (e + 1)) != 0) e++;
    m = 32'(i) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  function automatic logic [31:0] ref_pool(input plane_t p, input int orow, input int ocol);
    logic [31:0] m, x;
    m = 32'h0;
    for (int rr = 2*orow - 1; rr <= 2*orow + 1; rr++)
      for (int cc = 2*ocol - 1; cc <= 2*ocol + 1; cc++)
        if (rr >= 0 && rr < 4 && cc >= 0 && cc < 4) begin
          x = p[rr*4 + cc];
          if (x[31]) x = 32'h0;
          if (x > m) m = x;
        end
    return m;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (io.valid_out) begin
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL out[%0d] unexpected: got data=%h last=%b at cyc %0d, want no output", out_idx, io.pxl_out, io.last_out, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (io.pxl_out !== e.data || io.last_out !== e.last || cyc != e.due) begin
            fails++;
            $display("FAIL out[%0d]: got data=%h last=%b cyc=%0d, want data=%h last=%b cyc=%0d",
                     out_idx, io.pxl_out, io.last_out, cyc, e.data, e.last, e.due);
          end
        end
        out_idx++;
      end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
        exp_t e;
        e = sbq.pop_front();
        tests++;
        fails++;
        $display("FAIL out[%0d] missing: got valid_out=0 at cyc %0d, want data=%h last=%b", out_idx, cyc, e.data, e.last);
        out_idx++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic drive_one(input logic [31:0] d, input bit fire, input logic [31:0] e, input bit l);
    io.valid_in = 1'b1;
    io.pxl_in   = d;
    if (fire) sbq.push_back('{data: e, last: l, due: cyc + 2});
    @(posedge clk); #1;
  endtask

  task automatic drive_plane(input plane_t p, input pooled_t ex, input bit gaps);
    int k;
    for (int i = 0; i < 16; i++) begin
      if (gaps)
        while ($urandom_range(0, 1) == 0) begin
          io.valid_in = 1'b0;
          @(posedge clk); #1;
        end
      k = ((i / 4) / 2) * 2 + (i % 4) / 2;
      drive_one(p[i], ((i / 4) % 2 == 1) && (i % 2 == 1), ex[k], chan && (k == 3));
    end
    io.valid_in = 1'b0;
    chan = ~chan;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sbq.size() != 0; k++) @(posedge clk);
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d outputs still pending, want 0", sbq.size());
      sbq.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    io.valid_in = 1'b0;
    sbq.delete();
    chan = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t    vecs [6];
  plane_t  ramp, rnd;
  pooled_t ramp_exp, rnd_exp;

  initial begin
    io.valid_in = 1'b0;
    io.pxl_in   = 32'h0;

    for (int i = 0; i < 16; i++) ramp[i] = fbits(i);
    ramp_exp = {32'h41700000, 32'h41500000, 32'h40E00000, 32'h40A00000};

    vecs[0].pix = ramp; vecs[0].exp = ramp_exp; vecs[0].gaps = 1'b0;
    for (int i = 0; i < 16; i++) vecs[1].pix[i] = 32'hC0400000;
    vecs[1].pix[5] = 32'h80000000;
    vecs[1].exp = '0; vecs[1].gaps = 1'b0;
    vecs[2].pix = '0; vecs[2].pix[0] = 32'h41100000;
    vecs[2].exp = '0; vecs[2].exp[0] = 32'h41100000; vecs[2].gaps = 1'b0;
    vecs[3].pix = '0; vecs[3].pix[15] = 32'h41100000;
    vecs[3].exp = '0; vecs[3].exp[3] = 32'h41100000; vecs[3].gaps = 1'b0;
    vecs[4].pix = ramp; vecs[4].exp = ramp_exp; vecs[4].gaps = 1'b1;
    vecs[5].pix = ramp; vecs[5].exp = ramp_exp; vecs[5].gaps = 1'b0;

    #2 reset = 1'b1;
    #1;
    check("reset pxl_out", io.pxl_out, 32'h0);
    check("reset valid_out", {31'h0, io.valid_out}, 32'h0);
    check("reset last_out", {31'h0, io.last_out}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 6; t++) drive_plane(vecs[t].pix, vecs[t].exp, vecs[t].gaps);
    drain();

    for (int pl = 0; pl < 4; pl++) begin
      for (int i = 0; i < 16; i++) rnd[i] = $urandom() & 32'hBFFFFFFF;
      for (int k = 0; k < 4; k++) rnd_exp[k] = ref_pool(rnd, k / 2, k % 2);
      drive_plane(rnd, rnd_exp, 1'b0);
    end
    drain();

    do_reset();
    for (int i = 0; i < 9; i++)
      drive_one(fbits(i), (i == 5) || (i == 7), (i == 5) ? 32'h40A00000 : 32'h40E00000, 1'b0);
    check("pre-reset valid_out", {31'h0, io.valid_out}, 32'h1);
    reset = 1'b1;
    io.valid_in = 1'b0;
    #1;
    check("async reset valid_out", {31'h0, io.valid_out}, 32'h0);
    check("async reset last_out", {31'h0, io.last_out}, 32'h0);
    check("async reset pxl_out", io.pxl_out, 32'h0);
    sbq.delete();
    chan = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    drive_plane(ramp, ramp_exp, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
